// File: rtl/miter_sim_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : miter_sim_pkg
//  Description : Shared types, default geometry and the LFSR step function
//                used by the miter random-simulation driver.
//  Revision    : 1.0  initial release
// ============================================================================
package miter_sim_pkg;

  // Run-control states of the driver
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default primary-input width, feedback mask (x^10+x^7+1) and counter width
  localparam int                  c_n_in_def  = 10;
  localparam logic [c_n_in_def-1:0] c_taps_def = 10'h240;
  localparam int                  c_cnt_w_def = 16;

  // One Fibonacci step: shift left, new LSB is the parity of the tapped bits
  function automatic logic [c_n_in_def-1:0] lfsr_next(
    input logic [c_n_in_def-1:0] v,
    input logic [c_n_in_def-1:0] taps
  );
    return {v[c_n_in_def-2:0], ^(v & taps)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/miter_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : miter_lfsr
//  Description : Pattern LFSR with synchronous load and step enable. A zero
//                seed would lock the register up, so it loads all-ones then.
//  Revision    : 1.0  initial release
// ============================================================================
module miter_lfsr
  import miter_sim_pkg::*;
#(
  parameter int              N_IN = c_n_in_def,
  parameter logic [N_IN-1:0] TAPS = c_taps_def
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            enable,
  input  logic [N_IN-1:0] seed,
  output logic [N_IN-1:0] state
);

  logic [N_IN-1:0] r_state;
  logic [N_IN-1:0] w_next;
  logic [N_IN-1:0] w_seed_fix;

  assign w_seed_fix = (seed == '0) ? '1 : seed;

  // Default width reuses the shared step function; other widths step inline
  generate
    if (N_IN == c_n_in_def) begin : g_pkg_step
      assign w_next = lfsr_next(r_state, TAPS);
    end else begin : g_generic_step
      assign w_next = {r_state[N_IN-2:0], ^(r_state & TAPS)};
    end
  endgenerate

  // Pattern register: load has priority over stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
    end else if (load) begin
      r_state <= w_seed_fix;
    end else if (enable) begin
      r_state <= w_next;
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/miter_sim_driver.sv
`default_nettype none
// ============================================================================
//  Module      : miter_sim_driver
//  Description : Random-simulation front end for a golden/revised miter.
//                Drives both netlists from an LFSR, holds each pattern for
//                SETTLE_CYC cycles, counts mismatches and keeps the first
//                counterexample.
//  Options     : MITER_STOP_ON_FIRST_EN - end the run on the first mismatch
//                and leave pat_o parked on the counterexample.
//  Revision    : 1.0  initial release
// ============================================================================
module miter_sim_driver
  import miter_sim_pkg::*;
#(
  parameter int              N_IN       = c_n_in_def,
  parameter logic [N_IN-1:0] TAPS       = c_taps_def,
  parameter int              CNT_W      = c_cnt_w_def,
  parameter int              SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_IN-1:0]  seed,
  input  logic [CNT_W-1:0] num_patterns,
  output logic [N_IN-1:0]  pat_o,
  input  logic             gold_i,
  input  logic             rev_i,
  output logic             busy,
  output logic             done,
  output logic             mismatch_found,
  output logic [N_IN-1:0]  cex_o,
  output logic [CNT_W-1:0] pat_count_o,
  output logic [CNT_W-1:0] mismatch_count_o
);

  localparam int                  c_hold_w    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(SETTLE_CYC - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_hold_w-1:0] r_hold;
  logic [CNT_W-1:0]   r_num;
  logic [CNT_W-1:0]   r_pat_count;
  logic [CNT_W-1:0]   r_mm_count;
  logic [N_IN-1:0]    r_cex;
  logic               r_found;

  logic w_start_ok;
  logic w_sample;
  logic w_mismatch;
  logic w_last;
  logic w_stop;
  logic w_lfsr_adv;

  // A start pulse only counts while no run is in progress
  assign w_start_ok = start && (r_state != RUN);
  // Sample edge: the current pattern has been held for SETTLE_CYC cycles
  assign w_sample   = (r_state == RUN) && (r_hold == c_hold_last);
  assign w_mismatch = gold_i ^ rev_i;
  assign w_last     = ((r_pat_count + CNT_W'(1)) == r_num);

`ifdef MITER_STOP_ON_FIRST_EN
  assign w_stop = w_sample && w_mismatch && !r_found;
`else
  assign w_stop = 1'b0;
`endif

  // Park the LFSR on the counterexample when stopping early
  assign w_lfsr_adv = w_sample && !w_stop;

  miter_lfsr #(
    .N_IN (N_IN),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_start_ok),
    .enable (w_lfsr_adv),
    .seed   (seed),
    .state  (pat_o)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status decode
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = (num_patterns == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_sample && (w_last || w_stop)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (w_start_ok) begin
          w_state_nxt = (num_patterns == '0) ? DONE : RUN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Hold timer, counters and first-counterexample capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_num       <= '0;
      r_pat_count <= '0;
      r_mm_count  <= '0;
      r_cex       <= '0;
      r_found     <= 1'b0;
    end else if (w_start_ok) begin
      r_hold      <= '0;
      r_num       <= num_patterns;
      r_pat_count <= '0;
      r_mm_count  <= '0;
      r_cex       <= '0;
      r_found     <= 1'b0;
    end else if (r_state == RUN) begin
      if (w_sample) begin
        r_hold      <= '0;
        r_pat_count <= r_pat_count + CNT_W'(1);
        if (w_mismatch) begin
          if (r_mm_count != '1) begin
            r_mm_count <= r_mm_count + CNT_W'(1);
          end
          if (!r_found) begin
            r_cex   <= pat_o;
            r_found <= 1'b1;
          end
        end
      end else begin
        r_hold <= r_hold + c_hold_w'(1);
      end
    end
  end

  assign mismatch_found   = r_found;
  assign cex_o            = r_cex;
  assign pat_count_o      = r_pat_count;
  assign mismatch_count_o = r_mm_count;

endmodule
`default_nettype wire

// File: tb/tb_miter_sim_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_miter_sim_driver
//  Description : Self-checking bench for miter_sim_driver. Two instances
//                (hold 1 and hold 3 cycles) are compared every cycle against
//                a run-level model that derives all outputs from the number
//                of edges since the accepted start.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_miter_sim_driver;

  localparam logic [9:0] c_taps = 10'h240;
`ifdef MITER_STOP_ON_FIRST_EN
  localparam bit c_stop = 1'b1;
`else
  localparam bit c_stop = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        st   [2];
  logic [9:0]  sd   [2];
  logic [15:0] np   [2];
  logic [9:0]  pat  [2];
  logic        g    [2];
  logic        r    [2];
  logic        bsy  [2];
  logic        dn   [2];
  logic        mf   [2];
  logic [9:0]  cex  [2];
  logic [15:0] pc   [2];
  logic [15:0] mc   [2];
  int          mode [2];
  logic [9:0]  key  [2];

  miter_sim_driver #(.SETTLE_CYC(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .seed(sd[0]), .num_patterns(np[0]),
    .pat_o(pat[0]), .gold_i(g[0]), .rev_i(r[0]), .busy(bsy[0]), .done(dn[0]),
    .mismatch_found(mf[0]), .cex_o(cex[0]), .pat_count_o(pc[0]), .mismatch_count_o(mc[0])
  );

  miter_sim_driver #(.SETTLE_CYC(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .seed(sd[1]), .num_patterns(np[1]),
    .pat_o(pat[1]), .gold_i(g[1]), .rev_i(r[1]), .busy(bsy[1]), .done(dn[1]),
    .mismatch_found(mf[1]), .cex_o(cex[1]), .pat_count_o(pc[1]), .mismatch_count_o(mc[1])
  );

  // Whether golden and revised disagree on pattern p, per netlist-pair mode
  function automatic logic mfn(input int md, input logic [9:0] k, input logic [9:0] p);
    case (md)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (p == 10'h3FF);
      default: return p[9] && (p[3:0] == k[3:0]);
    endcase
  endfunction

  // Netlist stand-ins: golden is a&b, revised differs where mfn says so
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      g[i] = pat[i][9] & pat[i][8];
      r[i] = g[i] ^ mfn(mode[i], key[i], pat[i]);
    end
  end

  function automatic logic [9:0] adv(input logic [9:0] p);
    return {p[8:0], ^(p & c_taps)};
  endfunction

  typedef struct {
    logic [9:0]  pat;
    logic [9:0]  cex;
    logic        found;
    logic        busy;
    logic        done;
    logic [15:0] pc;
    logic [15:0] mc;
  } exp_t;

  // Outputs after e edges since the accepted start (e==0: nothing started)
  function automatic exp_t model(input int s_cyc, input logic [9:0] seed, input int n,
                                 input int md, input logic [9:0] k, input int e);
    exp_t       x;
    int         s;
    logic [9:0] p;
    bit         stopped;
    x = '{default: 0};
    if (e == 0) return x;
    s = (e - 1) / s_cyc;
    if (s > n) s = n;
    p = (seed == 10'd0) ? 10'h3FF : seed;
    stopped = 1'b0;
    for (int i = 0; i < s; i++) begin
      x.pc++;
      if (mfn(md, k, p)) begin
        if (x.mc != 16'hFFFF) x.mc++;
        if (!x.found) begin
          x.found = 1'b1;
          x.cex   = p;
          if (c_stop) begin
            stopped = 1'b1;
            break;
          end
        end
      end
      p = adv(p);
    end
    x.pat  = p;
    x.done = stopped || (int'(x.pc) == n);
    x.busy = !x.done;
    return x;
  endfunction

  int         e     [2];
  logic [9:0] mseed [2];
  int         mn    [2];
  int         mmode [2];
  logic [9:0] mkey  [2];

  function automatic int scyc(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Model bookkeeping: accepted starts restart the edge count
  always @(posedge clk or negedge rst_n) begin
    exp_t cur;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) e[i] = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        cur = model(scyc(i), mseed[i], mn[i], mmode[i], mkey[i], e[i]);
        if (st[i] && !cur.busy) begin
          e[i] = 1; mseed[i] = sd[i]; mn[i] = int'(np[i]); mmode[i] = mode[i]; mkey[i] = key[i];
        end else if (e[i] != 0) begin
          e[i] = e[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      x = model(scyc(i), mseed[i], mn[i], mmode[i], mkey[i], e[i]);
      chk($sformatf("dut%0d.pat_o", i),  32'(pat[i]), 32'(x.pat));
      chk($sformatf("dut%0d.cex_o", i),  32'(cex[i]), 32'(x.cex));
      chk($sformatf("dut%0d.found", i),  32'(mf[i]),  32'(x.found));
      chk($sformatf("dut%0d.busy", i),   32'(bsy[i]), 32'(x.busy));
      chk($sformatf("dut%0d.done", i),   32'(dn[i]),  32'(x.done));
      chk($sformatf("dut%0d.pat_cnt", i), 32'(pc[i]), 32'(x.pc));
      chk($sformatf("dut%0d.mm_cnt", i), 32'(mc[i]),  32'(x.mc));
    end
  end

  // Pulse start on instance i and wait (bounded) until it reports done
  task automatic go(input int i, input logic [9:0] s, input int n, input int md,
                    input logic [9:0] k, output int edges);
    @(posedge clk); #2;
    mode[i] = md; key[i] = k; sd[i] = s; np[i] = 16'(n); st[i] = 1'b1;
    @(posedge clk); #1;
    st[i] = 1'b0;
    edges = 1;
    while (!dn[i] && edges < 5000) begin
      @(posedge clk); #1;
      edges++;
    end
    chk($sformatf("dut%0d.done_timeout", i), 32'(dn[i]), 32'd1);
  endtask

  int ed;

  initial begin
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; sd[i] = '0; np[i] = '0; mode[i] = 0; key[i] = '0;
      mseed[i] = '0; mn[i] = 0; mmode[i] = 0; mkey[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset.pat_o", 32'(pat[0]), 32'd0);
    chk("reset.done",  32'(dn[0]),  32'd0);
    chk("reset.busy",  32'(bsy[1]), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Full period with matching netlists
    go(0, 10'h001, 1023, 0, 10'h000, ed);
    chk("t1.edges",   32'(ed),    32'd1024);
    chk("t1.pat_cnt", 32'(pc[0]), 32'd1023);
    chk("t1.mm_cnt",  32'(mc[0]), 32'd0);
    chk("t1.pat_o",   32'(pat[0]), 32'h001);

    // Always-different netlists
    go(0, 10'h155, 20, 1, 10'h000, ed);
    chk("t2.mm_cnt", 32'(mc[0]),  c_stop ? 32'd1 : 32'd20);
    chk("t2.cex",    32'(cex[0]), 32'h155);
    chk("t2.found",  32'(mf[0]),  32'd1);

    // Zero seed, mismatch only at all-ones
    go(0, 10'h000, 5, 2, 10'h000, ed);
    chk("t3.cex",    32'(cex[0]), 32'h3FF);
    chk("t3.mm_cnt", 32'(mc[0]),  32'd1);
    chk("t3.edges",  32'(ed),     c_stop ? 32'd2 : 32'd6);
    chk("t3.pat_cnt", 32'(pc[0]), c_stop ? 32'd1 : 32'd5);

    // Three-cycle hold
    go(1, 10'h2A5, 4, 0, 10'h000, ed);
    chk("t4.edges",   32'(ed),    32'd13);
    chk("t4.pat_cnt", 32'(pc[1]), 32'd4);

    // Start during RUN is ignored
    @(posedge clk); #2;
    mode[0] = 0; sd[0] = 10'h0AA; np[0] = 16'd30; st[0] = 1'b1;
    @(posedge clk); #1; st[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2; sd[0] = 10'h111; np[0] = 16'd3; st[0] = 1'b1;
    @(posedge clk); #1; st[0] = 1'b0;
    ed = 0;
    while (!dn[0] && ed < 200) begin @(posedge clk); #1; ed++; end
    chk("t5.pat_cnt", 32'(pc[0]), 32'd30);

    // Zero-length run
    go(0, 10'h0C3, 0, 1, 10'h000, ed);
    chk("t5.n0_edges", 32'(ed),     32'd1);
    chk("t5.n0_cnt",   32'(pc[0]),  32'd0);
    chk("t5.n0_pat",   32'(pat[0]), 32'h0C3);

    // Asynchronous reset in the middle of a run
    @(posedge clk); #2;
    mode[0] = 3; key[0] = 10'h005; sd[0] = 10'h0F0; np[0] = 16'd40; st[0] = 1'b1;
    @(posedge clk); #1; st[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("t6.pat_cnt_pre", 32'(pc[0]), 32'd7);
    #2; rst_n = 1'b0; #1;
    chk("t6.rst_pat", 32'(pat[0]), 32'd0);
    chk("t6.rst_cnt", 32'(pc[0]),  32'd0);
    chk("t6.rst_busy", 32'(bsy[0]), 32'd0);
    chk("t6.rst_cex", 32'(cex[0]), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    go(0, 10'h3C3, 25, 1, 10'h000, ed);
    chk("t6.rerun_cnt", 32'(pc[0]),  c_stop ? 32'd1 : 32'd25);
    chk("t6.rerun_cex", 32'(cex[0]), 32'h3C3);

    // Randomized runs on both instances
    for (int t = 0; t < 14; t++) begin
      go(int'($urandom_range(0, 1)), 10'($urandom), int'($urandom_range(0, 40)),
         int'($urandom_range(0, 3)), 10'($urandom), ed);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
